// File: rtl/quad_gate_tester.sv
// Self-test sequencer for one quad 2-input gate IP (AND/OR/NAND/NOR).
// Walks four rotated input vectors, samples Y after a settle time and reports per-gate failures.
module quad_gate_tester #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [1:0]  FUNC          = 2'd1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] a_out,
   output logic [3:0] b_out,
   input  logic [3:0] y_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [1:0] fail_vec
);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] mask_q, mask_d;
   logic [1:0] fvec_q, fvec_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic [3:0] exp_y;
   logic [3:0] mismatch;

   // Gate i gets code (v+i) mod 4 so every gate sees a different combination per step.
   function automatic logic [3:0] code_a(input logic [1:0] v);
      logic [1:0] c;
      for (int i = 0; i < 4; i++) begin
         c         = v + 2'(i);
         code_a[i] = c[1];
      end
   endfunction

   function automatic logic [3:0] code_b(input logic [1:0] v);
      logic [1:0] c;
      for (int i = 0; i < 4; i++) begin
         c         = v + 2'(i);
         code_b[i] = c[0];
      end
   endfunction

   function automatic logic [3:0] gate_expect(input logic [3:0] a, input logic [3:0] b);
      case (FUNC)
         2'd0:    gate_expect = a & b;
         2'd1:    gate_expect = a | b;
         2'd2:    gate_expect = ~(a & b);
         default: gate_expect = ~(a | b);
      endcase
   endfunction

   // a_q/b_q hold the current vector during SAMPLE, so expected Y derives from them.
   assign exp_y    = gate_expect(a_q, b_q);
   assign mismatch = y_in ^ exp_y;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      mask_d  = mask_q;
      fvec_d  = fvec_q;
      pass_d  = pass_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            a_d = '0;
            b_d = '0;
            if (start) begin
               state_d = StSettle;
               vec_d   = 2'd0;
               cnt_d   = 8'd0;
               mask_d  = '0;
               fvec_d  = 2'd0;
               pass_d  = 1'b0;
               a_d     = code_a(2'd0);
               b_d     = code_b(2'd0);
            end
         end

         StSettle: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q >= SettleLast) begin
               state_d = StSample;
            end
         end

         StSample: begin
            mask_d = mask_q | mismatch;
            if ((mask_q == 4'd0) && (mismatch != 4'd0)) begin
               fvec_d = vec_q;
            end
            if (vec_q == 2'd3) begin
               state_d = StDone;
               done_d  = 1'b1;
               pass_d  = ((mask_q | mismatch) == 4'd0);
               a_d     = '0;
               b_d     = '0;
            end else begin
               state_d = StSettle;
               vec_d   = vec_q + 2'd1;
               cnt_d   = 8'd0;
               a_d     = code_a(vec_q + 2'd1);
               b_d     = code_b(vec_q + 2'd1);
            end
         end

         StDone: begin
            state_d = StIdle;
            a_d     = '0;
            b_d     = '0;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         vec_q   <= 2'd0;
         cnt_q   <= 8'd0;
         a_q     <= '0;
         b_q     <= '0;
         mask_q  <= '0;
         fvec_q  <= 2'd0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mask_q  <= mask_d;
         fvec_q  <= fvec_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;
   assign fail_vec  = fvec_q;

endmodule
